eth_tx_arbiter: RTL

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter_if.sv | 27 ++
 rtl/eth_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter_if.sv
// Handshake bundle between the Ethernet TX arbiter and its packet-builder
// channels. The slave modport is the arbiter side, the master modport is the
// side that owns the requests and builders.
interface eth_tx_arbiter_if #(
    parameter int NCH  = 4,
    parameter int SELW = 2
);
    logic [NCH-1:0]  i_req;
    logic [NCH-1:0]  i_evt;
    logic [NCH-1:0]  i_rdy;
    logic [SELW-1:0] o_sel;
    logic            o_active;
    logic [NCH-1:0]  o_start;
    logic            o_done;
    logic            o_tmo;
    logic [NCH-1:0]  o_evt_pend;

    modport slave (
        input  i_req, i_evt, i_rdy,
        output o_sel, o_active, o_start, o_done, o_tmo, o_evt_pend
    );

    modport master (
        output i_req, i_evt, i_rdy,
        input  o_sel, o_active, o_start, o_done, o_tmo, o_evt_pend
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Ethernet TX arbiter: grants one packet-builder channel at a time, waits for
// that builder to finish (rising edge of its ready), then forces GAP idle
// cycles before the next arbitration. Fixed-priority or round-robin search.
// Optional watchdog abort is enabled by defining ETH_TX_ARB_TMO_EN.
module eth_tx_arbiter #(
    parameter int NCH     = 4,
    parameter int SELW    = 2,
    parameter int RR_MODE = 0,
    parameter int GAP     = 3,
    parameter int TMO_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    eth_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAPW   = 2'd2
    } arbState_t;

    // Parameter sanity checks at elaboration time
    generate
        if (NCH < 2 || NCH > 8) begin : g_badNch
            $error("eth_tx_arbiter: NCH must be in 2..8");
        end
        if (SELW != $clog2(NCH)) begin : g_badSelw
            $error("eth_tx_arbiter: SELW must equal clog2(NCH)");
        end
        if (GAP < 0 || GAP > 255) begin : g_badGap
            $error("eth_tx_arbiter: GAP must be in 0..255");
        end
        if (TMO_CYC < 1 || TMO_CYC > 16777215) begin : g_badTmo
            $error("eth_tx_arbiter: TMO_CYC must be in 1..2^24-1");
        end
    endgenerate

    logic [1:0]      r_rstSync;
    logic            w_rstN;

    logic [NCH-1:0]  r_evtCur;
    logic [NCH-1:0]  r_evtPrev;
    logic [NCH-1:0]  r_evtPend;
    logic [NCH-1:0]  w_evtSet;
    logic [NCH-1:0]  r_rdyQ;
    logic [NCH-1:0]  w_elig;

    arbState_t       r_state;
    logic [SELW-1:0] r_sel;
    logic            r_active;
    logic [NCH-1:0]  r_start;
    logic            r_done;
    logic            r_tmo;
    logic [7:0]      r_gapCnt;

    logic [SELW-1:0] w_pick;
    logic            w_done;
    logic            w_tmoHit;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    // A pending event is a 0->1 transition seen in the two-deep event history
    assign w_evtSet = r_evtCur & ~r_evtPrev;

    // Latch event edges and keep a one-cycle-old copy of builder ready
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_evtCur  <= '0;
            r_evtPrev <= '0;
            r_evtPend <= '0;
            r_rdyQ    <= '0;
        end else begin
            r_evtCur  <= bus.i_evt;
            r_evtPrev <= r_evtCur;
            r_evtPend <= w_evtSet | (r_evtPend & ~r_start);
            r_rdyQ    <= bus.i_rdy;
        end
    end

    assign w_elig = (bus.i_req | r_evtPend) & bus.i_rdy;

    // Builder completion is the rising edge of the granted channel's ready
    assign w_done = (r_state == ACTIVE) && !r_rdyQ[r_sel] && bus.i_rdy[r_sel];

    generate
        if (RR_MODE != 0) begin : g_rr
            logic [SELW-1:0] r_lastGrant;
            logic            w_found;

            // Search eligible channels starting one past the previous winner
            always_comb begin
                w_pick  = '0;
                w_found = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (!w_found && w_elig[(int'(r_lastGrant) + 1 + i) % NCH]) begin
                        w_found = 1'b1;
                        w_pick  = SELW'((int'(r_lastGrant) + 1 + i) % NCH);
                    end
                end
            end

            // Remember the winner of each grant so the next search starts after it
            always_ff @(posedge clk or negedge w_rstN) begin
                if (!w_rstN) begin
                    r_lastGrant <= SELW'(NCH - 1);
                end else if (r_state == IDLE && (|w_elig)) begin
                    r_lastGrant <= w_pick;
                end
            end
        end else begin : g_fixed
            // Lowest eligible index wins; scan downward so the last hit is the lowest
            always_comb begin
                w_pick = '0;
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (w_elig[i]) begin
                        w_pick = SELW'(i);
                    end
                end
            end
        end
    endgenerate

`ifdef ETH_TX_ARB_TMO_EN
    logic [23:0] r_tmoCnt;

    // Count cycles spent waiting on the granted builder; zero on entry to ACTIVE
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_tmoCnt <= '0;
        end else if (r_state == ACTIVE) begin
            r_tmoCnt <= r_tmoCnt + 24'd1;
        end else begin
            r_tmoCnt <= '0;
        end
    end

    assign w_tmoHit = (r_state == ACTIVE) && (r_tmoCnt == 24'(TMO_CYC - 1));
`else
    assign w_tmoHit = 1'b0;
`endif

    // Arbitration FSM with registered grant, start, done and timeout outputs
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_active <= 1'b0;
            r_start  <= '0;
            r_done   <= 1'b0;
            r_tmo    <= 1'b0;
            r_gapCnt <= '0;
        end else begin
            r_start <= '0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_state  <= ACTIVE;
                        r_sel    <= w_pick;
                        r_active <= 1'b1;
                        r_start  <= NCH'(1) << w_pick;
                    end
                end
                ACTIVE: begin
                    if (w_done || w_tmoHit) begin
                        r_active <= 1'b0;
                        r_done   <= w_done;
                        r_tmo    <= w_tmoHit & ~w_done;
                        r_gapCnt <= '0;
                        r_state  <= (GAP == 0) ? IDLE : GAPW;
                    end
                end
                GAPW: begin
                    if (r_gapCnt == 8'(GAP - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_sel      = r_sel;
    assign bus.o_active   = r_active;
    assign bus.o_start    = r_start;
    assign bus.o_done     = r_done;
    assign bus.o_tmo      = r_tmo;
    assign bus.o_evt_pend = r_evtPend;

endmodule
